// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// ifu_pkg : shared FSM encoding, instruction sizing and immediate helpers
// Rev 1.0
// ============================================================================
package ifu_pkg;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } ifu_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  localparam int IMM26_HI = 25;
  localparam int IMM26_LO = 0;
  localparam int IMM19_HI = 23;
  localparam int IMM19_LO = 5;
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 21;

  // Word-granular immediates become signed byte offsets.
  function automatic logic [63:0] sext_imm26(input logic [25:0] imm);
    return {{36{imm[25]}}, imm, 2'b00};
  endfunction

  function automatic logic [63:0] sext_imm19(input logic [18:0] imm);
    return {{43{imm[18]}}, imm, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_target_gen.sv
`default_nettype none
// ============================================================================
// branch_target_gen : combinational next-PC from held PC, word and branch info
// Rev 1.0
// ============================================================================
module branch_target_gen
  import ifu_pkg::*;
(
  input  logic [63:0] InstrPC,
  input  logic [31:0] Instruction,
  input  logic        Uncondbranch,
  input  logic        Taken,
  output logic [63:0] NextPC
);

  logic [63:0] offset;
  logic        unused_instr_hi;

  // Opcode bits never contribute to the target.
  assign unused_instr_hi = ^Instruction[31:26];

  always_comb begin
    offset = Uncondbranch ? sext_imm26(Instruction[IMM26_HI:IMM26_LO])
                          : sext_imm19(Instruction[IMM19_HI:IMM19_LO]);
    NextPC = Taken ? (InstrPC + offset) : (InstrPC + 64'(INSTR_BYTES));
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// instruction_fetch_unit : PC, fetch handshake and instruction hold register.
// Optional retire/taken counters built when IFU_PERF_COUNT_EN is defined.
// Rev 1.0
// ============================================================================
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        ImemReq,
  output logic [63:0] ImemAddr,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRdata,
  output logic        InstrValid,
  output logic [31:0] Instruction,
  output logic [10:0] Opcode,
  output logic [63:0] InstrPC,
  input  logic        InstrAccept,
  input  logic        Branch,
  input  logic        Uncondbranch,
  input  logic        Zero,
  output logic [31:0] InstrCount,
  output logic [31:0] TakenCount
);

  ifu_state_e  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] instr_pc_q, instr_pc_d;
  logic [63:0] next_pc;
  logic        taken;

  assign taken = Uncondbranch | (Branch & Zero);

  branch_target_gen u_btg (
    .InstrPC      (instr_pc_q),
    .Instruction  (instr_q),
    .Uncondbranch (Uncondbranch),
    .Taken        (taken),
    .NextPC       (next_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      ST_FETCH: begin
        if (ImemRespValid) begin
          state_d    = ST_HOLD;
          instr_d    = ImemRdata;
          instr_pc_d = pc_q;
        end
      end
      ST_HOLD: begin
        if (InstrAccept) begin
          state_d = ST_FETCH;
          pc_d    = next_pc;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Reset gates the handshake outputs within the same cycle.
  assign ImemReq     = ~Reset & (state_q == ST_FETCH);
  assign InstrValid  = ~Reset & (state_q == ST_HOLD);
  assign ImemAddr    = pc_q;
  assign Instruction = instr_q;
  assign Opcode      = instr_q[OPC_HI:OPC_LO];
  assign InstrPC     = instr_pc_q;

`ifdef IFU_PERF_COUNT_EN
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] taken_count_q, taken_count_d;
  logic        retire;

  assign retire = (state_q == ST_HOLD) & InstrAccept;

  always_comb begin
    instr_count_d = instr_count_q;
    taken_count_d = taken_count_q;
    if (retire) begin
      instr_count_d = instr_count_q + 32'd1;
      if (taken) taken_count_d = taken_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      instr_count_q <= 32'd0;
      taken_count_q <= 32'd0;
    end else begin
      instr_count_q <= instr_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign InstrCount = instr_count_q;
  assign TakenCount = taken_count_q;
`else
  assign InstrCount = 32'd0;
  assign TakenCount = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_instruction_fetch_unit : directed self-checking bench for the fetch unit
// and the standalone branch target generator. Rev 1.0
// ============================================================================
module tb_instruction_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h100;
`ifdef IFU_PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] W_ADD  = 32'h8B02_0020;
  localparam logic [31:0] W_ADD2 = 32'h8B03_0041;
  localparam logic [31:0] W_CBZ4 = 32'hB400_0080;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        ImemReq;
  logic [63:0] ImemAddr;
  logic        ImemRespValid = 1'b0;
  logic [31:0] ImemRdata = 32'd0;
  logic        InstrValid;
  logic [31:0] Instruction;
  logic [10:0] Opcode;
  logic [63:0] InstrPC;
  logic        InstrAccept = 1'b0;
  logic        Branch = 1'b0;
  logic        Uncondbranch = 1'b0;
  logic        Zero = 1'b0;
  logic [31:0] InstrCount;
  logic [31:0] TakenCount;

  logic [63:0] btg_pc = 64'd0;
  logic [31:0] btg_instr = 32'd0;
  logic        btg_unc = 1'b0;
  logic        btg_taken = 1'b0;
  logic [63:0] btg_next;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .ImemReq       (ImemReq),
    .ImemAddr      (ImemAddr),
    .ImemRespValid (ImemRespValid),
    .ImemRdata     (ImemRdata),
    .InstrValid    (InstrValid),
    .Instruction   (Instruction),
    .Opcode        (Opcode),
    .InstrPC       (InstrPC),
    .InstrAccept   (InstrAccept),
    .Branch        (Branch),
    .Uncondbranch  (Uncondbranch),
    .Zero          (Zero),
    .InstrCount    (InstrCount),
    .TakenCount    (TakenCount)
  );

  branch_target_gen u_btg_solo (
    .InstrPC      (btg_pc),
    .Instruction  (btg_instr),
    .Uncondbranch (btg_unc),
    .Taken        (btg_taken),
    .NextPC       (btg_next)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic logic [63:0] cnt(input int n);
    return PERF ? 64'(n) : 64'd0;
  endfunction

  initial begin
    // Standalone target generator, extreme immediates and fall-through.
    btg_pc = 64'h1000; btg_instr = 32'h1600_0000; btg_unc = 1'b1; btg_taken = 1'b1; #1;
    chk("btg_b_min", btg_next, 64'hFFFF_FFFF_F800_1000);
    btg_instr = 32'hB480_0000; btg_unc = 1'b0; #1;
    chk("btg_cbz_min", btg_next, 64'hFFFF_FFFF_FFF0_1000);
    btg_taken = 1'b0; #1;
    chk("btg_seq", btg_next, 64'h1004);

    tick();  // C0 reset edge
    // C1: still in reset, response offered but must be ignored
    ImemRespValid = 1'b1; ImemRdata = W_ADD; #1;
    chk("rst_req", 64'(ImemReq), 64'd0);
    chk("rst_valid", 64'(InstrValid), 64'd0);
    chk("rst_addr", ImemAddr, RST_PC);
    chk("rst_instr", 64'(Instruction), 64'd0);
    chk("rst_ipc", InstrPC, 64'd0);
    chk("rst_icnt", 64'(InstrCount), 64'd0);
    chk("rst_tcnt", 64'(TakenCount), 64'd0);
    tick();
    // C2: first request, same-cycle response
    Reset = 1'b0; InstrAccept = 1'b1; #1;
    chk("c2_req", 64'(ImemReq), 64'd1);
    chk("c2_addr", ImemAddr, 64'h100);
    chk("c2_instr", 64'(Instruction), 64'd0);
    tick();
    // C3
    chk("c3_valid", 64'(InstrValid), 64'd1);
    chk("c3_req", 64'(ImemReq), 64'd0);
    chk("c3_opc", 64'(Opcode), 64'b100_0101_1000);
    chk("c3_ipc", InstrPC, 64'h100);
    tick();
    // C4
    chk("c4_addr", ImemAddr, 64'h104);
    chk("c4_valid", 64'(InstrValid), 64'd0);
    tick();
    // C5
    chk("c5_ipc", InstrPC, 64'h104);
    tick();
    // C6: B +0x3E words to reach 0x200
    chk("c6_addr", ImemAddr, 64'h108);
    chk("c6_icnt", 64'(InstrCount), cnt(2));
    ImemRdata = 32'h1400_003E;
    tick();
    // C7
    Uncondbranch = 1'b1; #1;
    chk("c7_ipc", InstrPC, 64'h108);
    tick();
    // C8: B -2 words at 0x200
    Uncondbranch = 1'b0; ImemRdata = 32'h17FF_FFFE; #1;
    chk("c8_addr", ImemAddr, 64'h200);
    chk("c8_tcnt", 64'(TakenCount), cnt(1));
    tick();
    // C9
    Uncondbranch = 1'b1; #1;
    chk("c9_instr", 64'(Instruction), 64'h17FF_FFFE);
    tick();
    // C10
    Uncondbranch = 1'b0; ImemRdata = 32'h1400_0042; #1;
    chk("b_back_addr", ImemAddr, 64'h1F8);
    chk("b_back_tcnt", 64'(TakenCount), cnt(2));
    tick();
    // C11
    Uncondbranch = 1'b1;
    tick();
    // C12: CBZ +4 words at 0x300
    Uncondbranch = 1'b0; ImemRdata = W_CBZ4; #1;
    chk("c12_addr", ImemAddr, 64'h300);
    tick();
    // C13
    Branch = 1'b1; Zero = 1'b1;
    tick();
    // C14
    Branch = 1'b0; Zero = 1'b0; ImemRdata = 32'h17FF_FFFC; #1;
    chk("cbz_taken", ImemAddr, 64'h310);
    tick();
    // C15
    Uncondbranch = 1'b1;
    tick();
    // C16
    Uncondbranch = 1'b0; ImemRdata = W_CBZ4; #1;
    chk("c16_addr", ImemAddr, 64'h300);
    tick();
    // C17
    Branch = 1'b1; Zero = 1'b0;
    tick();
    // C18: slow memory, branch inputs asserted outside HOLD
    InstrAccept = 1'b0; ImemRespValid = 1'b0; Zero = 1'b1; #1;
    chk("cbz_not_taken", ImemAddr, 64'h304);
    chk("c18_icnt", 64'(InstrCount), cnt(8));
    chk("c18_tcnt", 64'(TakenCount), cnt(5));
    tick();
    // C19
    chk("wait1_addr", ImemAddr, 64'h304);
    chk("wait1_req", 64'(ImemReq), 64'd1);
    tick();
    // C20
    Branch = 1'b0; Zero = 1'b0; ImemRespValid = 1'b1; ImemRdata = W_ADD2; #1;
    chk("wait2_addr", ImemAddr, 64'h304);
    tick();
    // C21-C24: held without accept, spurious response in HOLD
    ImemRdata = 32'hDEAD_BEEF; #1;
    chk("hold0_instr", 64'(Instruction), 64'(W_ADD2));
    tick();
    ImemRespValid = 1'b0; #1;
    chk("hold1_instr", 64'(Instruction), 64'(W_ADD2));
    chk("hold1_ipc", InstrPC, 64'h304);
    tick();
    chk("hold2_valid", 64'(InstrValid), 64'd1);
    tick();
    chk("hold3_instr", 64'(Instruction), 64'(W_ADD2));
    chk("hold3_icnt", 64'(InstrCount), cnt(8));
    tick();
    // C25: reset while accept pending
    Reset = 1'b1; InstrAccept = 1'b1; #1;
    chk("rst_hold_valid", 64'(InstrValid), 64'd0);
    chk("rst_hold_req", 64'(ImemReq), 64'd0);
    tick();
    // C26
    chk("rst2_icnt", 64'(InstrCount), 64'd0);
    chk("rst2_tcnt", 64'(TakenCount), 64'd0);
    chk("rst2_valid", 64'(InstrValid), 64'd0);
    chk("rst2_addr", ImemAddr, RST_PC);
    tick();
    // C27: restart, B -0x41 words to land at 0xFF..FC
    Reset = 1'b0; ImemRespValid = 1'b1; ImemRdata = 32'h17FF_FFBF; InstrAccept = 1'b0; #1;
    chk("restart_req", 64'(ImemReq), 64'd1);
    chk("restart_addr", ImemAddr, 64'h100);
    tick();
    // C28
    Uncondbranch = 1'b1; InstrAccept = 1'b1; #1;
    chk("c28_ipc", InstrPC, 64'h100);
    tick();
    // C29
    Uncondbranch = 1'b0; ImemRdata = W_ADD; #1;
    chk("top_addr", ImemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    // C30
    chk("top_ipc", InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    // C31
    chk("wrap_addr", ImemAddr, 64'h0);
    chk("wrap_icnt", 64'(InstrCount), cnt(2));
    chk("wrap_tcnt", 64'(TakenCount), cnt(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
